// File: rtl/rob_pkg.sv
// Shared opcode constants and opcode classification helpers for the
// multi-port reorder buffer.
package rob_pkg;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_OPIMM = 7'b0010011;
    localparam logic [6:0] OP_OP    = 7'b0110011;

    function automatic logic has_rd(input logic [6:0] op);
        case (op)
            OP_OP, OP_OPIMM, OP_LOAD, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI: has_rd = 1'b1;
            default: has_rd = 1'b0;
        endcase
    endfunction

    function automatic logic is_serial(input logic [6:0] op);
        case (op)
            OP_BR, OP_JALR, OP_LOAD, OP_STORE: is_serial = 1'b1;
            default: is_serial = 1'b0;
        endcase
    endfunction

    function automatic logic is_mem(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE: is_mem = 1'b1;
            default: is_mem = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rob_multiport_if.sv
// Bus bundle between the reorder buffer (slave) and dispatch, CDB, register
// file and fetch-redirect logic (master).
interface rob_multiport_if #(
    parameter int DEPTH     = 32,
    parameter int ID_W      = $clog2(DEPTH),
    parameter int XLEN      = 32,
    parameter int CDB_PORTS = 2,
    parameter int LOOKUPS   = 2,
    parameter int COMMIT_W  = 2
);
    logic                        rdy_in;
    logic                        disp_valid;
    logic                        disp_ready;
    logic [6:0]                  disp_type;
    logic [XLEN-1:0]             disp_pc;
    logic [4:0]                  disp_rd;
    logic [XLEN-1:0]             disp_value;
    logic [XLEN-1:0]             disp_imm;
    logic                        disp_rvc;
    logic [ID_W-1:0]             disp_tag;
    logic [LOOKUPS*ID_W-1:0]     lk_tag;
    logic [LOOKUPS-1:0]          lk_done;
    logic [LOOKUPS*XLEN-1:0]     lk_value;
    logic [CDB_PORTS-1:0]        cdb_valid;
    logic [CDB_PORTS*ID_W-1:0]   cdb_tag;
    logic [CDB_PORTS*XLEN-1:0]   cdb_value;
    logic [COMMIT_W-1:0]         cm_valid;
    logic [COMMIT_W-1:0]         cm_has_rd;
    logic [COMMIT_W*5-1:0]       cm_rd;
    logic [COMMIT_W*ID_W-1:0]    cm_tag;
    logic [COMMIT_W*XLEN-1:0]    cm_value;
    logic                        flush;
    logic                        redirect_valid;
    logic [XLEN-1:0]             redirect_pc;
    logic                        mem_head_pulse;
    logic [ID_W-1:0]             mem_head_tag;
    logic [ID_W:0]               count;

    modport slave (
        input  rdy_in, disp_valid, disp_type, disp_pc, disp_rd, disp_value,
               disp_imm, disp_rvc, lk_tag, cdb_valid, cdb_tag, cdb_value,
        output disp_ready, disp_tag, lk_done, lk_value, cm_valid, cm_has_rd,
               cm_rd, cm_tag, cm_value, flush, redirect_valid, redirect_pc,
               mem_head_pulse, mem_head_tag, count
    );

    modport master (
        output rdy_in, disp_valid, disp_type, disp_pc, disp_rd, disp_value,
               disp_imm, disp_rvc, lk_tag, cdb_valid, cdb_tag, cdb_value,
        input  disp_ready, disp_tag, lk_done, lk_value, cm_valid, cm_has_rd,
               cm_rd, cm_tag, cm_value, flush, redirect_valid, redirect_pc,
               mem_head_pulse, mem_head_tag, count
    );
endinterface

// File: rtl/rob_cdb_bypass.sv
// Priority matcher of one tag against all CDB channels; the highest-numbered
// matching channel supplies the data.
module rob_cdb_bypass #(
    parameter int ID_W      = 5,
    parameter int XLEN      = 32,
    parameter int CDB_PORTS = 2
) (
    input  logic [ID_W-1:0]           tag,
    input  logic [CDB_PORTS-1:0]      cdb_valid,
    input  logic [CDB_PORTS*ID_W-1:0] cdb_tag,
    input  logic [CDB_PORTS*XLEN-1:0] cdb_value,
    output logic                      hit,
    output logic [XLEN-1:0]           data
);
    logic            match_s;
    logic            hit_s;
    logic [XLEN-1:0] data_s;

    // Scan channels in ascending order so later (higher) matches override.
    always_comb begin
        match_s = 1'b0;
        hit_s   = 1'b0;
        data_s  = '0;
        for (int k = 0; k < CDB_PORTS; k++) begin
            match_s = cdb_valid[k] & (cdb_tag[k*ID_W +: ID_W] == tag);
            hit_s   = hit_s | match_s;
            data_s  = match_s ? cdb_value[k*XLEN +: XLEN] : data_s;
        end
    end

    assign hit  = hit_s;
    assign data = data_s;
endmodule

// File: rtl/rob_multiport.sv
// Parametrised reorder buffer: N CDB write-backs, bypassed operand lookup,
// 1- or 2-wide in-order commit and branch/JALR redirect generation.
module rob_multiport
    import rob_pkg::*;
#(
    parameter int DEPTH     = 32,
    parameter int ID_W      = $clog2(DEPTH),
    parameter int XLEN      = 32,
    parameter int CDB_PORTS = 2,
    parameter int LOOKUPS   = 2,
    parameter int COMMIT_W  = 2
) (
    input logic             clk_in,
    input logic             rst_n_in,
    rob_multiport_if.slave  bus
);
    logic [DEPTH-1:0] valid_r;
    logic [DEPTH-1:0] done_r;
    logic [DEPTH-1:0] rvc_r;
    logic [6:0]       type_r  [DEPTH];
    logic [4:0]       rd_r    [DEPTH];
    logic [XLEN-1:0]  pc_r    [DEPTH];
    logic [XLEN-1:0]  value_r [DEPTH];
    logic [XLEN-1:0]  imm_r   [DEPTH];

    logic [ID_W-1:0]  head_r;
    logic [ID_W-1:0]  tail_r;
    logic [ID_W:0]    count_r;
    logic             pulse_r;

    logic [DEPTH-1:0] wb_hit_s;
    logic [XLEN-1:0]  wb_data_s [DEPTH];

    logic [LOOKUPS-1:0]      lk_hit_s;
    logic [XLEN-1:0]         lk_data_s [LOOKUPS];
    logic [ID_W-1:0]         lk_tag_s  [LOOKUPS];
    logic [LOOKUPS-1:0]      lk_done_s;
    logic [LOOKUPS*XLEN-1:0] lk_value_s;

    logic [ID_W-1:0]  h1_s;
    logic             c0_s;
    logic             c1_s;
    logic [1:0]       ncm_s;
    logic [COMMIT_W-1:0] cm_ok_s;
    logic [ID_W-1:0]  cm_idx_s [COMMIT_W];
    logic [COMMIT_W-1:0]      cm_has_rd_s;
    logic [COMMIT_W*5-1:0]    cm_rd_s;
    logic [COMMIT_W*ID_W-1:0] cm_tag_s;
    logic [COMMIT_W*XLEN-1:0] cm_value_s;

    logic             is_br_s;
    logic             is_jalr_s;
    logic             flush_s;
    logic             redir_valid_s;
    logic [XLEN-1:0]  redir_pc_s;

    logic             disp_ready_s;
    logic             disp_fire_s;
    logic [ID_W+1:0]  cnt_wide_s;
    logic [ID_W:0]    cnt_next_s;
    logic [ID_W-1:0]  nh_s;
    logic             head_moves_s;
    logic             nh_mem_s;
    logic             pulse_next_s;

    // One matcher per entry resolves same-cycle duplicate CDB tags for write-back.
    for (genvar e = 0; e < DEPTH; e++) begin : g_wb
        rob_cdb_bypass #(.ID_W(ID_W), .XLEN(XLEN), .CDB_PORTS(CDB_PORTS)) u_wb (
            .tag       (ID_W'(e)),
            .cdb_valid (bus.cdb_valid),
            .cdb_tag   (bus.cdb_tag),
            .cdb_value (bus.cdb_value),
            .hit       (wb_hit_s[e]),
            .data      (wb_data_s[e])
        );
    end

    for (genvar i = 0; i < LOOKUPS; i++) begin : g_lk
        assign lk_tag_s[i] = bus.lk_tag[i*ID_W +: ID_W];
        rob_cdb_bypass #(.ID_W(ID_W), .XLEN(XLEN), .CDB_PORTS(CDB_PORTS)) u_lk (
            .tag       (lk_tag_s[i]),
            .cdb_valid (bus.cdb_valid),
            .cdb_tag   (bus.cdb_tag),
            .cdb_value (bus.cdb_value),
            .hit       (lk_hit_s[i]),
            .data      (lk_data_s[i])
        );
    end

    // Operand lookup: CDB bypass wins over stored state.
    always_comb begin
        lk_done_s  = '0;
        lk_value_s = '0;
        for (int i = 0; i < LOOKUPS; i++) begin
            lk_done_s[i] = lk_hit_s[i] | done_r[lk_tag_s[i]];
            lk_value_s[i*XLEN +: XLEN] = lk_hit_s[i] ? lk_data_s[i] : value_r[lk_tag_s[i]];
        end
    end

    // Commit slot selection and per-slot retire fields.
    always_comb begin
        h1_s  = head_r + ID_W'(1);
        c0_s  = bus.rdy_in & valid_r[head_r] & done_r[head_r];
        c1_s  = (COMMIT_W == 2) & c0_s & valid_r[h1_s] & done_r[h1_s]
              & ~is_serial(type_r[head_r]) & ~is_serial(type_r[h1_s]);
        ncm_s = {1'b0, c0_s} + {1'b0, c1_s};
        cm_has_rd_s = '0;
        cm_rd_s     = '0;
        cm_tag_s    = '0;
        cm_value_s  = '0;
        for (int s = 0; s < COMMIT_W; s++) begin
            cm_idx_s[s] = head_r + ID_W'(s);
            cm_ok_s[s]  = (s == 0) ? c0_s : c1_s;
            cm_has_rd_s[s] = cm_ok_s[s] & has_rd(type_r[cm_idx_s[s]])
                           & (rd_r[cm_idx_s[s]] != 5'd0);
            cm_rd_s[s*5 +: 5]        = cm_ok_s[s] ? rd_r[cm_idx_s[s]] : 5'd0;
            cm_tag_s[s*ID_W +: ID_W] = cm_ok_s[s] ? cm_idx_s[s] : '0;
            cm_value_s[s*XLEN +: XLEN] = cm_ok_s[s] ? value_r[cm_idx_s[s]] : '0;
        end
    end

    // Branch resolution and redirect target for the head entry.
    always_comb begin
        is_br_s       = c0_s & (type_r[head_r] == OP_BR);
        is_jalr_s     = c0_s & (type_r[head_r] == OP_JALR);
        flush_s       = is_br_s & (rd_r[head_r][0] != value_r[head_r][0]);
        redir_valid_s = flush_s | is_jalr_s;
        if (flush_s) begin
            redir_pc_s = value_r[head_r][0] ? (pc_r[head_r] + imm_r[head_r])
                       : (pc_r[head_r] + (rvc_r[head_r] ? XLEN'(32'd2) : XLEN'(32'd4)));
        end else if (is_jalr_s) begin
            redir_pc_s = imm_r[head_r];
        end else begin
            redir_pc_s = '0;
        end
    end

    // Dispatch acceptance, occupancy update and head-onto-memory-op detection.
    always_comb begin
        disp_ready_s = (count_r < (ID_W+1)'(DEPTH));
        disp_fire_s  = bus.rdy_in & bus.disp_valid & disp_ready_s & ~flush_s;
        cnt_wide_s   = {1'b0, count_r} + (ID_W+2)'(disp_fire_s) - (ID_W+2)'(ncm_s);
        if (cnt_wide_s[ID_W+1]) begin
            cnt_next_s = '0;
        end else if (cnt_wide_s > (ID_W+2)'(DEPTH)) begin
            cnt_next_s = (ID_W+1)'(DEPTH);
        end else begin
            cnt_next_s = cnt_wide_s[ID_W:0];
        end
        nh_s         = head_r + ID_W'(ncm_s);
        head_moves_s = (ncm_s != 2'd0) | ((count_r == '0) & disp_fire_s);
        nh_mem_s     = valid_r[nh_s] ? is_mem(type_r[nh_s])
                     : (disp_fire_s & (tail_r == nh_s) & is_mem(bus.disp_type));
        pulse_next_s = head_moves_s & nh_mem_s;
    end

    // Entry storage and pointers; order inside the else branch sets priority
    // CDB write < commit clear < dispatch write.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            pulse_r <= 1'b0;
            valid_r <= '0;
            done_r  <= '0;
            rvc_r   <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                type_r[e]  <= 7'd0;
                rd_r[e]    <= 5'd0;
                pc_r[e]    <= '0;
                value_r[e] <= '0;
                imm_r[e]   <= '0;
            end
        end else if (bus.rdy_in) begin
            if (flush_s) begin
                head_r  <= '0;
                tail_r  <= '0;
                count_r <= '0;
                pulse_r <= 1'b0;
                valid_r <= '0;
                done_r  <= '0;
            end else begin
                for (int e = 0; e < DEPTH; e++) begin
                    if (wb_hit_s[e] && valid_r[e]) begin
                        done_r[e] <= 1'b1;
                        if (type_r[e] == OP_JALR) begin
                            imm_r[e] <= wb_data_s[e];
                        end else begin
                            value_r[e] <= wb_data_s[e];
                        end
                    end
                end
                for (int s = 0; s < COMMIT_W; s++) begin
                    if (cm_ok_s[s]) begin
                        valid_r[cm_idx_s[s]] <= 1'b0;
                        done_r[cm_idx_s[s]]  <= 1'b0;
                    end
                end
                if (disp_fire_s) begin
                    valid_r[tail_r] <= 1'b1;
                    done_r[tail_r]  <= (bus.disp_type == OP_LUI);
                    rvc_r[tail_r]   <= bus.disp_rvc;
                    type_r[tail_r]  <= bus.disp_type;
                    rd_r[tail_r]    <= bus.disp_rd;
                    pc_r[tail_r]    <= bus.disp_pc;
                    value_r[tail_r] <= bus.disp_value;
                    imm_r[tail_r]   <= bus.disp_imm;
                end
                head_r  <= nh_s;
                tail_r  <= tail_r + ID_W'(disp_fire_s);
                count_r <= cnt_next_s;
                pulse_r <= pulse_next_s;
            end
        end
    end

    assign bus.disp_ready     = disp_ready_s;
    assign bus.disp_tag       = tail_r;
    assign bus.lk_done        = lk_done_s;
    assign bus.lk_value       = lk_value_s;
    assign bus.cm_valid       = cm_ok_s;
    assign bus.cm_has_rd      = cm_has_rd_s;
    assign bus.cm_rd          = cm_rd_s;
    assign bus.cm_tag         = cm_tag_s;
    assign bus.cm_value       = cm_value_s;
    assign bus.flush          = flush_s;
    assign bus.redirect_valid = redir_valid_s;
    assign bus.redirect_pc    = redir_pc_s;
    assign bus.mem_head_pulse = pulse_r & bus.rdy_in;
    assign bus.mem_head_tag   = head_r;
    assign bus.count          = count_r;
endmodule

// File: tb/tb_rob_multiport.sv
// Directed bench for rob_multiport: a vector table for dispatch/CDB/lookup/commit
// plus hand-written sequences for full, load-at-head, mispredict and JALR cases.
module tb_rob_multiport;
    localparam int DEPTH = 32;
    localparam int ID_W  = 5;
    localparam int XLEN  = 32;
    localparam logic [6:0] T_ALU  = 7'b0110011;
    localparam logic [6:0] T_LOAD = 7'b0000011;
    localparam logic [6:0] T_BR   = 7'b1100011;
    localparam logic [6:0] T_JALR = 7'b1100111;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    rob_multiport_if #(.DEPTH(DEPTH), .ID_W(ID_W), .XLEN(XLEN),
                       .CDB_PORTS(2), .LOOKUPS(2), .COMMIT_W(2)) bus ();

    rob_multiport #(.DEPTH(DEPTH), .ID_W(ID_W), .XLEN(XLEN),
                    .CDB_PORTS(2), .LOOKUPS(2), .COMMIT_W(2)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        dv;
        logic [6:0]  dtype;
        logic [4:0]  drd;
        logic [1:0]  cv;
        logic [4:0]  ct0;
        logic [31:0] cd0;
        logic [4:0]  ct1;
        logic [31:0] cd1;
        logic [4:0]  lk0;
        logic [4:0]  lk1;
        logic [4:0]  e_tag;
        logic [1:0]  e_cmv;
        logic [1:0]  e_lkd;
        logic [31:0] e_lk0;
        logic [31:0] e_lk1;
        logic [31:0] e_cm0;
        logic [31:0] e_cm1;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.rdy_in     = 1'b1;
        bus.disp_valid = 1'b0;
        bus.disp_type  = 7'd0;
        bus.disp_pc    = 32'd0;
        bus.disp_rd    = 5'd0;
        bus.disp_value = 32'd0;
        bus.disp_imm   = 32'd0;
        bus.disp_rvc   = 1'b0;
        bus.lk_tag     = 10'd0;
        bus.cdb_valid  = 2'b00;
        bus.cdb_tag    = 10'd0;
        bus.cdb_value  = 64'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic disp(input logic [6:0] t, input logic [4:0] rd, input logic [31:0] pc,
                        input logic [31:0] imm, input logic rvc);
        bus.disp_valid = 1'b1;
        bus.disp_type  = t;
        bus.disp_rd    = rd;
        bus.disp_pc    = pc;
        bus.disp_imm   = imm;
        bus.disp_rvc   = rvc;
        bus.disp_value = 32'd0;
    endtask

    task automatic cdb(input int k, input logic [4:0] tag, input logic [31:0] val);
        bus.cdb_valid[k]          = 1'b1;
        bus.cdb_tag[k*5 +: 5]     = tag;
        bus.cdb_value[k*32 +: 32] = val;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;

        //  dv dtype  rd  cv    ct0 cd0     ct1 cd1     lk0 lk1 tag cmv   lkd   lk0v    lk1v    cm0     cm1     cnt
        tbl[0] = '{1'b1, T_ALU, 5'd1, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0,  5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 32'h0,  32'h0,  32'h0,  32'h0,  6'd1};
        tbl[1] = '{1'b1, T_ALU, 5'd2, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0,  5'd0, 5'd0, 5'd1, 2'b00, 2'b00, 32'h0,  32'h0,  32'h0,  32'h0,  6'd2};
        tbl[2] = '{1'b1, T_ALU, 5'd3, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0,  5'd0, 5'd0, 5'd2, 2'b00, 2'b00, 32'h0,  32'h0,  32'h0,  32'h0,  6'd3};
        tbl[3] = '{1'b0, T_ALU, 5'd0, 2'b11, 5'd1, 32'hAA, 5'd1, 32'hBB, 5'd1, 5'd0, 5'd3, 2'b00, 2'b01, 32'hBB, 32'h0,  32'h0,  32'h0,  6'd3};
        tbl[4] = '{1'b0, T_ALU, 5'd0, 2'b01, 5'd0, 32'h11, 5'd0, 32'h0,  5'd1, 5'd0, 5'd3, 2'b00, 2'b11, 32'hBB, 32'h11, 32'h0,  32'h0,  6'd3};
        tbl[5] = '{1'b0, T_ALU, 5'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0,  5'd1, 5'd0, 5'd3, 2'b11, 2'b11, 32'hBB, 32'h11, 32'h11, 32'hBB, 6'd1};
        tbl[6] = '{1'b0, T_ALU, 5'd0, 2'b01, 5'd2, 32'h22, 5'd0, 32'h0,  5'd2, 5'd2, 5'd3, 2'b00, 2'b11, 32'h22, 32'h22, 32'h0,  32'h0,  6'd1};
        tbl[7] = '{1'b0, T_ALU, 5'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0,  5'd2, 5'd2, 5'd3, 2'b01, 2'b11, 32'h22, 32'h22, 32'h22, 32'h0,  6'd0};

        do_reset();
        chk("rst_count", bus.count, 6'd0);
        chk("rst_ready", bus.disp_ready, 1'b1);
        chk("rst_tag", bus.disp_tag, 5'd0);
        chk("rst_cmv", bus.cm_valid, 2'b00);
        chk("rst_flush", bus.flush, 1'b0);
        chk("rst_redir", bus.redirect_valid, 1'b0);
        chk("rst_pulse", bus.mem_head_pulse, 1'b0);

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].dv) disp(tbl[i].dtype, tbl[i].drd, 32'h0, 32'h0, 1'b0);
            bus.cdb_valid = tbl[i].cv;
            bus.cdb_tag   = {tbl[i].ct1, tbl[i].ct0};
            bus.cdb_value = {tbl[i].cd1, tbl[i].cd0};
            bus.lk_tag    = {tbl[i].lk1, tbl[i].lk0};
            #4;
            chk($sformatf("tbl%0d_tag", i), bus.disp_tag, tbl[i].e_tag);
            chk($sformatf("tbl%0d_cmv", i), bus.cm_valid, tbl[i].e_cmv);
            chk($sformatf("tbl%0d_lkd", i), bus.lk_done, tbl[i].e_lkd);
            chk($sformatf("tbl%0d_lk0", i), bus.lk_value[31:0], tbl[i].e_lk0);
            chk($sformatf("tbl%0d_lk1", i), bus.lk_value[63:32], tbl[i].e_lk1);
            chk($sformatf("tbl%0d_cm0", i), bus.cm_value[31:0], tbl[i].e_cm0);
            chk($sformatf("tbl%0d_cm1", i), bus.cm_value[63:32], tbl[i].e_cm1);
            step();
            chk($sformatf("tbl%0d_cnt", i), bus.count, tbl[i].e_cnt);
        end

        // Fill to DEPTH, try an extra dispatch, retire one, wrap the tail.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            disp(T_ALU, 5'd5, 32'h0, 32'h0, 1'b0);
            #4;
            chk($sformatf("full_tag%0d", i), bus.disp_tag, i[4:0]);
            step();
        end
        chk("full_count", bus.count, 6'd32);
        chk("full_ready", bus.disp_ready, 1'b0);
        disp(T_ALU, 5'd5, 32'h0, 32'h0, 1'b0);
        step();
        chk("full_33_count", bus.count, 6'd32);
        chk("full_33_tag", bus.disp_tag, 5'd0);
        cdb(0, 5'd0, 32'h55);
        step();
        disp(T_ALU, 5'd5, 32'h0, 32'h0, 1'b0);
        #4;
        chk("full_cmv", bus.cm_valid, 2'b01);
        chk("full_cm0", bus.cm_value[31:0], 32'h55);
        chk("full_ready_cm", bus.disp_ready, 1'b0);
        step();
        chk("full_retire_count", bus.count, 6'd31);
        disp(T_ALU, 5'd5, 32'h0, 32'h0, 1'b0);
        #4;
        chk("wrap_tag", bus.disp_tag, 5'd0);
        step();
        chk("wrap_count", bus.count, 6'd32);

        // Load at head+1 blocks dual commit and pulses once when it reaches head.
        do_reset();
        disp(T_ALU, 5'd1, 32'h0, 32'h0, 1'b0);  step();
        disp(T_LOAD, 5'd2, 32'h0, 32'h0, 1'b0); step();
        disp(T_ALU, 5'd3, 32'h0, 32'h0, 1'b0);  step();
        chk("ld_count", bus.count, 6'd3);
        cdb(0, 5'd0, 32'h10);
        cdb(1, 5'd1, 32'h20);
        step();
        #4;
        chk("ld_cmv0", bus.cm_valid, 2'b01);
        chk("ld_pulse0", bus.mem_head_pulse, 1'b0);
        step();
        #4;
        chk("ld_pulse1", bus.mem_head_pulse, 1'b1);
        chk("ld_mtag", bus.mem_head_tag, 5'd1);
        chk("ld_cmv1", bus.cm_valid, 2'b01);
        chk("ld_hasrd", bus.cm_has_rd, 2'b01);
        chk("ld_rd", bus.cm_rd[4:0], 5'd2);
        chk("ld_cm0", bus.cm_value[31:0], 32'h20);
        step();
        #4;
        chk("ld_pulse2", bus.mem_head_pulse, 1'b0);
        chk("ld_cmv2", bus.cm_valid, 2'b00);
        chk("ld_count2", bus.count, 6'd1);

        // Mispredicted not-taken branch: flush, redirect to pc+imm, dispatch dropped.
        do_reset();
        disp(T_BR, 5'd0, 32'h100, 32'h40, 1'b0); step();
        disp(T_ALU, 5'd1, 32'h0, 32'h0, 1'b0);   step();
        cdb(0, 5'd0, 32'h1);
        step();
        disp(T_ALU, 5'd2, 32'h0, 32'h0, 1'b0);
        #4;
        chk("br_cmv", bus.cm_valid, 2'b01);
        chk("br_flush", bus.flush, 1'b1);
        chk("br_redir", bus.redirect_valid, 1'b1);
        chk("br_pc", bus.redirect_pc, 32'h140);
        step();
        chk("br_count", bus.count, 6'd0);
        chk("br_tag", bus.disp_tag, 5'd0);
        #4;
        chk("br_cmv_after", bus.cm_valid, 2'b00);
        chk("br_flush_after", bus.flush, 1'b0);

        // Mispredicted taken compressed branch: redirect to pc+2.
        disp(T_BR, 5'd1, 32'h200, 32'h80, 1'b1); step();
        cdb(0, 5'd0, 32'h0);
        step();
        #4;
        chk("brc_flush", bus.flush, 1'b1);
        chk("brc_pc", bus.redirect_pc, 32'h202);
        step();
        chk("brc_count", bus.count, 6'd0);

        // Correctly predicted taken branch: plain retire, no redirect.
        disp(T_BR, 5'd1, 32'h300, 32'h10, 1'b0); step();
        cdb(0, 5'd0, 32'h1);
        step();
        #4;
        chk("brok_cmv", bus.cm_valid, 2'b01);
        chk("brok_flush", bus.flush, 1'b0);
        chk("brok_redir", bus.redirect_valid, 1'b0);
        step();
        chk("brok_count", bus.count, 6'd0);

        // JALR at head redirects to CDB target without flushing; pause holds state.
        do_reset();
        disp(T_JALR, 5'd1, 32'h300, 32'h0, 1'b0); step();
        disp(T_ALU, 5'd2, 32'h0, 32'h0, 1'b0);    step();
        disp(T_ALU, 5'd3, 32'h0, 32'h0, 1'b0);    step();
        cdb(0, 5'd0, 32'h2000);
        cdb(1, 5'd1, 32'h77);
        step();
        #4;
        chk("jr_cmv", bus.cm_valid, 2'b01);
        chk("jr_redir", bus.redirect_valid, 1'b1);
        chk("jr_pc", bus.redirect_pc, 32'h2000);
        chk("jr_flush", bus.flush, 1'b0);
        step();
        chk("jr_count", bus.count, 6'd2);
        bus.rdy_in = 1'b0;
        #4;
        chk("pause_cmv", bus.cm_valid, 2'b00);
        step();
        chk("pause_count", bus.count, 6'd2);
        #4;
        chk("jr_next_cmv", bus.cm_valid, 2'b01);
        chk("jr_next_cm0", bus.cm_value[31:0], 32'h77);
        chk("jr_next_tag", bus.cm_tag[4:0], 5'd1);
        step();
        chk("jr_next_count", bus.count, 6'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
